// File: rtl/datamem_ctrl_if.sv
// datamem_ctrl request/response bus.
// Master issues MEM-stage commands, slave returns write-back data.
interface datamem_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              memwrite;
  logic              memread;
  logic              memtoreg;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] datawrite;
  logic [DATA_W-1:0] readdata;
  logic              rd_valid;
  logic              addr_err;
  logic              init_done;

  modport master (
    output req_valid,
    output memwrite,
    output memread,
    output memtoreg,
    output address,
    output datawrite,
    input  req_ready,
    input  readdata,
    input  rd_valid,
    input  addr_err,
    input  init_done
  );

  modport slave (
    input  req_valid,
    input  memwrite,
    input  memread,
    input  memtoreg,
    input  address,
    input  datawrite,
    output req_ready,
    output readdata,
    output rd_valid,
    output addr_err,
    output init_done
  );
endinterface

// File: rtl/datamem_ctrl.sv
// MEM-stage data memory with init sweep and registered write-back.
// Define DATAMEM_PRELOAD_EN to preload the boot table into words 0..7.
module datamem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic           clk,
  input logic           rst,
  datamem_ctrl_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Full-width bound so out-of-range indices never wrap.
  localparam logic [DATA_W:0] LIMIT = (DATA_W + 1)'(DEPTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] readdata_d;
  logic              rd_valid_q;
  logic              rd_valid_d;
  logic              addr_err_q;
  logic              addr_err_d;

  logic              running;
  logic              accept;
  logic              in_range;
  logic              last_init;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] init_val;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

`ifdef DATAMEM_PRELOAD_EN
  function automatic logic [DATA_W-1:0] boot_word(
    input logic [IDX_W-1:0] i
  );
    logic [15:0] w;
    case (32'(i))
      32'd0:   w = 16'h0012;
      32'd1:   w = 16'h0003;
      32'd2:   w = 16'h0011;
      32'd3:   w = 16'h0004;
      32'd4:   w = 16'h0014;
      32'd5:   w = 16'h0002;
      32'd6:   w = 16'h0009;
      32'd7:   w = 16'h0014;
      default: w = 16'h0000;
    endcase
    return DATA_W'(w);
  endfunction

  assign init_val = boot_word(cnt_q);
`else
  assign init_val = '0;
`endif

  assign running   = (state_q == S_RUN);
  assign accept    = bus.req_valid & running;
  assign in_range  = ({1'b0, bus.address} < LIMIT);
  assign word_addr = bus.address[ADDR_W-1:0];
  assign idx       = IDX_W'(word_addr);
  assign rd_word   = mem_q[idx];
  assign last_init = (cnt_q == LAST_IDX);

  // FSM state and init counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: sweep every word once, then run until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (last_init) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
    endcase
  end

  // FSM outputs: handshake opens only in RUN
  always_comb begin
    bus.req_ready = 1'b0;
    bus.init_done = 1'b0;
    unique case (state_q)
      S_INIT: begin
        bus.req_ready = 1'b0;
        bus.init_done = 1'b0;
      end
      S_RUN: begin
        bus.req_ready = 1'b1;
        bus.init_done = 1'b1;
      end
    endcase
  end

  // Write port: init sweep owns it in INIT, accepted writes in RUN
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_q;
    mem_wd = init_val;
    if (state_q == S_INIT) begin
      mem_we = 1'b1;
    end else if (accept && bus.memwrite && in_range) begin
      mem_we = 1'b1;
      mem_wa = idx;
      mem_wd = bus.datawrite;
    end
  end

  // Storage array; contents are rebuilt by the init sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Write-back selection; array is read before this edge's write
  always_comb begin
    readdata_d = readdata_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (accept) begin
      if (!bus.memtoreg) begin
        readdata_d = bus.address;
        rd_valid_d = 1'b1;
      end else begin
        if (bus.memread) begin
          readdata_d = in_range ? rd_word : '0;
          rd_valid_d = 1'b1;
        end
        addr_err_d = (bus.memread | bus.memwrite) & ~in_range;
      end
    end
  end

  // Registered write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule
